// File: rtl/sprite_motion_pkg.sv
// -----------------------------------------------------------------------------
// sprite_motion_pkg
// Shared definitions for the sprite motion block:
//   - sprite-space screen size and the full-resolution first blanking line,
//     common with the VGA timing controller
//   - coordinate width
//   - motion FSM state encoding
//   - axis_advance(): the bounce arithmetic used for both X and Y
// -----------------------------------------------------------------------------
package sprite_motion_pkg;

    localparam int COORD_W      = 16;
    localparam int SCREEN_W_DEF = 200;
    localparam int SCREEN_H_DEF = 150;
    localparam int V_ACTIVE_DEF = 600;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE_X = 2'd1,
        ST_MOVE_Y = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               dir;
        logic               bounce;
    } axis_res_t;

    // One axis step with reflection at 0 and max_pos.
    // dir 0 moves toward max_pos, dir 1 toward 0. A zero step leaves the
    // axis untouched (no reflection even when sitting on an edge).
    // The sum is formed one bit wider so a large step can never wrap.
    function automatic axis_res_t axis_advance(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic [3:0]         step,
        input logic [COORD_W-1:0] max_pos
    );
        axis_res_t          res;
        logic [COORD_W-1:0] step_w;
        logic [COORD_W:0]   sum;
        step_w     = {12'd0, step};
        sum        = {1'b0, pos} + {1'b0, step_w};
        res.pos    = pos;
        res.dir    = dir;
        res.bounce = 1'b0;
        if (step == 4'd0) begin
            res.pos    = pos;
            res.dir    = dir;
            res.bounce = 1'b0;
        end else if (dir == 1'b0) begin
            if (sum >= {1'b0, max_pos}) begin
                res.pos    = max_pos;
                res.dir    = 1'b1;
                res.bounce = 1'b1;
            end else begin
                res.pos = sum[COORD_W-1:0];
            end
        end else begin
            if (pos <= step_w) begin
                res.pos    = {COORD_W{1'b0}};
                res.dir    = 1'b0;
                res.bounce = 1'b1;
            end else begin
                res.pos = pos - step_w;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sprite_motion_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// sprite_motion_frame_tick_gen
// Detects the start of vertical blanking (horz==0, vert==V_ACTIVE), emits a
// one-cycle frame tick in the following cycle, and divides frames by
// FRAME_DIV while enabled.
// Ports:
//   i_pix_clk, i_reset_n     : pixel clock, async active-low reset
//   i_horz_coord/i_vert_coord: full-resolution coordinates
//   i_enable                 : divider advances only while high
//   o_tick                   : registered, high the cycle after the match
//   o_update_req             : high in the match cycle when the divider wraps;
//                              combinational so the FSM is in MOVE_X during
//                              the tick cycle
// -----------------------------------------------------------------------------
module sprite_motion_frame_tick_gen
    import sprite_motion_pkg::*;
#(
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int FRAME_DIV = 2
) (
    input  logic               i_pix_clk,
    input  logic               i_reset_n,
    input  logic [COORD_W-1:0] i_horz_coord,
    input  logic [COORD_W-1:0] i_vert_coord,
    input  logic               i_enable,
    output logic               o_tick,
    output logic               o_update_req
);

    localparam int              DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    logic             w_match;
    logic             w_wrap;
    logic             r_tick;
    logic [DIV_W-1:0] r_div_cnt;

    assign w_match      = (i_horz_coord == {COORD_W{1'b0}}) &&
                          (i_vert_coord == COORD_W'(V_ACTIVE));
    assign w_wrap       = (r_div_cnt == DIV_LAST);
    assign o_update_req = w_match && i_enable && w_wrap;
    assign o_tick       = r_tick;

    // Frame tick: delayed copy of the coordinate match.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_match;
        end
    end

    // Frame divider: counts ticks while enabled, holds otherwise.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div_cnt <= {DIV_W{1'b0}};
        end else if (w_match && i_enable) begin
            if (w_wrap) begin
                r_div_cnt <= {DIV_W{1'b0}};
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end else begin
            r_div_cnt <= r_div_cnt;
        end
    end

endmodule

// File: rtl/sprite_motion.sv
// -----------------------------------------------------------------------------
// sprite_motion
// Sprite position generator in sprite-space (full resolution / 4). Once every
// FRAME_DIV frames, during vertical blanking, the position is advanced by the
// step inputs and reflected off the screen edges. New X and Y are built in
// shadow registers over two cycles and committed together so the outputs only
// change inside blanking.
// Ports:
//   i_pix_clk, i_reset_n       : pixel clock, async active-low reset
//   i_horz_coord, i_vert_coord : full-resolution coordinates (16 bit)
//   i_enable                   : 0 freezes position, direction and divider
//   i_step_x, i_step_y         : per-update step, sampled in the tick cycle
//   o_sprite_x, o_sprite_y     : committed top-left position
//   o_dir_x, o_dir_y           : 0 = increasing, 1 = decreasing
//   o_frame_tick               : one pulse per frame
//   o_bounce                   : one pulse on commit if either axis reflected
// -----------------------------------------------------------------------------
module sprite_motion
    import sprite_motion_pkg::*;
#(
    parameter int SCREEN_W  = SCREEN_W_DEF,
    parameter int SCREEN_H  = SCREEN_H_DEF,
    parameter int SPRITE_W  = 16,
    parameter int SPRITE_H  = 16,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int FRAME_DIV = 2,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0
) (
    input  logic               i_pix_clk,
    input  logic               i_reset_n,
    input  logic [COORD_W-1:0] i_horz_coord,
    input  logic [COORD_W-1:0] i_vert_coord,
    input  logic               i_enable,
    input  logic [3:0]         i_step_x,
    input  logic [3:0]         i_step_y,
    output logic [COORD_W-1:0] o_sprite_x,
    output logic [COORD_W-1:0] o_sprite_y,
    output logic               o_dir_x,
    output logic               o_dir_y,
    output logic               o_frame_tick,
    output logic               o_bounce
);

    localparam logic [COORD_W-1:0] MAX_X  = COORD_W'(SCREEN_W - SPRITE_W);
    localparam logic [COORD_W-1:0] MAX_Y  = COORD_W'(SCREEN_H - SPRITE_H);
    localparam logic [COORD_W-1:0] INIT_XV = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] INIT_YV = COORD_W'(INIT_Y);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_update_req;
    logic               w_tick;

    logic [COORD_W-1:0] r_sprite_x;
    logic [COORD_W-1:0] r_sprite_y;
    logic               r_dir_x;
    logic               r_dir_y;
    logic               r_bounce;

    logic [COORD_W-1:0] r_shadow_x;
    logic [COORD_W-1:0] r_shadow_y;
    logic               r_shadow_dx;
    logic               r_shadow_dy;
    logic               r_bounce_flag;
    logic [3:0]         r_step_y;

    axis_res_t          w_res_x;
    axis_res_t          w_res_y;

    sprite_motion_frame_tick_gen #(
        .V_ACTIVE  (V_ACTIVE),
        .FRAME_DIV (FRAME_DIV)
    ) u_tick_gen (
        .i_pix_clk    (i_pix_clk),
        .i_reset_n    (i_reset_n),
        .i_horz_coord (i_horz_coord),
        .i_vert_coord (i_vert_coord),
        .i_enable     (i_enable),
        .o_tick       (w_tick),
        .o_update_req (w_update_req)
    );

    // X uses the live step in MOVE_X (the tick cycle); Y uses the step
    // captured in that same cycle so later step changes cannot leak in.
    assign w_res_x = axis_advance(r_sprite_x, r_dir_x, i_step_x, MAX_X);
    assign w_res_y = axis_advance(r_sprite_y, r_dir_y, r_step_y, MAX_Y);

    assign o_sprite_x   = r_sprite_x;
    assign o_sprite_y   = r_sprite_y;
    assign o_dir_x      = r_dir_x;
    assign o_dir_y      = r_dir_y;
    assign o_bounce     = r_bounce;
    assign o_frame_tick = w_tick;

    // FSM state register.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; requests outside IDLE are ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_update_req) begin
                    w_state_nxt = ST_MOVE_X;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MOVE_X: w_state_nxt = ST_MOVE_Y;
            ST_MOVE_Y: w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Shadow datapath: build the next position one axis per cycle.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shadow_x    <= INIT_XV;
            r_shadow_y    <= INIT_YV;
            r_shadow_dx   <= 1'b0;
            r_shadow_dy   <= 1'b0;
            r_bounce_flag <= 1'b0;
            r_step_y      <= 4'd0;
        end else begin
            case (r_state)
                ST_MOVE_X: begin
                    r_shadow_x    <= w_res_x.pos;
                    r_shadow_dx   <= w_res_x.dir;
                    r_bounce_flag <= w_res_x.bounce;
                    r_step_y      <= i_step_y;
                end
                ST_MOVE_Y: begin
                    r_shadow_y    <= w_res_y.pos;
                    r_shadow_dy   <= w_res_y.dir;
                    r_bounce_flag <= r_bounce_flag | w_res_y.bounce;
                end
                default: begin
                    r_shadow_x    <= r_shadow_x;
                    r_shadow_y    <= r_shadow_y;
                    r_shadow_dx   <= r_shadow_dx;
                    r_shadow_dy   <= r_shadow_dy;
                    r_bounce_flag <= r_bounce_flag;
                    r_step_y      <= r_step_y;
                end
            endcase
        end
    end

    // Committed outputs: updated together in COMMIT, bounce pulses one cycle.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sprite_x <= INIT_XV;
            r_sprite_y <= INIT_YV;
            r_dir_x    <= 1'b0;
            r_dir_y    <= 1'b0;
            r_bounce   <= 1'b0;
        end else if (r_state == ST_COMMIT) begin
            r_sprite_x <= r_shadow_x;
            r_sprite_y <= r_shadow_y;
            r_dir_x    <= r_shadow_dx;
            r_dir_y    <= r_shadow_dy;
            r_bounce   <= r_bounce_flag;
        end else begin
            r_sprite_x <= r_sprite_x;
            r_sprite_y <= r_sprite_y;
            r_dir_x    <= r_dir_x;
            r_dir_y    <= r_dir_y;
            r_bounce   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_motion.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion
// Drives a compressed VGA raster (8 pixels per line, a few active lines, then
// blanking lines from 600 upward) into sprite_motion with random steps and
// enable, and compares every cycle against a frame-level motion model.
// -----------------------------------------------------------------------------
module tb_sprite_motion;

    localparam int SW    = 200;
    localparam int SH    = 150;
    localparam int SPW   = 16;
    localparam int SPH   = 16;
    localparam int FDIV  = 2;
    localparam int MAXX  = SW - SPW;
    localparam int MAXY  = SH - SPH;
    localparam int HTOT  = 8;
    localparam int NLINE = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] horz;
    logic [15:0] vert;
    logic        en;
    logic [3:0]  sx;
    logic [3:0]  sy;
    logic [15:0] ox;
    logic [15:0] oy;
    logic        odx;
    logic        ody;
    logic        otick;
    logic        obounce;

    always #5 clk = ~clk;

    sprite_motion dut (
        .i_pix_clk    (clk),
        .i_reset_n    (rst_n),
        .i_horz_coord (horz),
        .i_vert_coord (vert),
        .i_enable     (en),
        .i_step_x     (sx),
        .i_step_y     (sy),
        .o_sprite_x   (ox),
        .o_sprite_y   (oy),
        .o_dir_x      (odx),
        .o_dir_y      (ody),
        .o_frame_tick (otick),
        .o_bounce     (obounce)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int mx, my, mdx, mdy, mdiv, stage, psx, psy;
    int exp_tick, exp_bounce;
    int tick_seen;
    int prev_v;
    logic [63:0] prev_pack;
    bit skip_stable;
    bit rand_steps;
    bit rst_mid_pending;
    bit rst_mid_done;
    int line_tab [NLINE];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One axis move, stated directly: clamp into 0..max, reflect on reaching an edge.
    task automatic model_axis(inout int p, inout int d, input int s, input int maxp, output int b);
        b = 0;
        if (s != 0) begin
            if (d == 0) begin
                p = (p + s < maxp) ? p + s : maxp;
                if (p == maxp) begin d = 1; b = 1; end
            end else begin
                p = (p - s > 0) ? p - s : 0;
                if (p == 0) begin d = 0; b = 1; end
            end
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mdx = 0; mdy = 0; mdiv = 0; stage = 0;
        exp_tick = 0; exp_bounce = 0;
    endtask

    task automatic one_cycle(input int h, input int v);
        int old_stage;
        int bx, by;
        if (rand_steps && ($urandom_range(0, 3) == 0)) begin
            sx = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            sy = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end
        horz = 16'(h);
        vert = 16'(v);
        @(posedge clk);
        #1;
        exp_tick   = (h == 0 && v == 600) ? 1 : 0;
        exp_bounce = 0;
        old_stage  = stage;
        case (stage)
            1: begin psx = int'(sx); psy = int'(sy); stage = 2; end
            2: stage = 3;
            3: begin
                model_axis(mx, mdx, psx, MAXX, bx);
                model_axis(my, mdy, psy, MAXY, by);
                exp_bounce = (bx | by);
                stage = 0;
            end
            default: stage = 0;
        endcase
        if (h == 0 && v == 600 && en) begin
            mdiv++;
            if (mdiv == FDIV) begin
                mdiv = 0;
                if (old_stage == 0) stage = 1;
            end
        end
        if (otick) tick_seen++;
        check_val("x", 64'(ox), 64'(mx));
        check_val("y", 64'(oy), 64'(my));
        check_val("dir_x", 64'(odx), 64'(mdx));
        check_val("dir_y", 64'(ody), 64'(mdy));
        check_val("tick", 64'(otick), 64'(exp_tick));
        check_val("bounce", 64'(obounce), 64'(exp_bounce));
        if (v < 600 && prev_v < 600 && !skip_stable)
            check_val("active_stable", {30'd0, ox, oy, odx, ody}, prev_pack);
        skip_stable = 0;
        prev_pack   = {30'd0, ox, oy, odx, ody};
        prev_v      = v;
        if (rst_mid_pending && stage == 2) begin
            // now in MOVE_Y: X already computed into the shadow registers
            rst_n = 1'b0;
            #1;
            check_val("rst_mid_x", 64'(ox), 64'd0);
            check_val("rst_mid_y", 64'(oy), 64'd0);
            check_val("rst_mid_dir", {62'd0, odx, ody}, 64'd0);
            model_reset();
            rst_mid_pending = 0;
            rst_mid_done    = 1;
            skip_stable     = 1;
            #1;
            rst_n = 1'b1;
        end
    endtask

    task automatic run_frame();
        for (int l = 0; l < NLINE; l++)
            for (int h = 0; h < HTOT; h++)
                one_cycle(h, line_tab[l]);
    endtask

    initial begin
        int sv_x, sv_y, sv_dx, sv_dy;
        line_tab[0] = 0;   line_tab[1] = 150; line_tab[2] = 300;
        line_tab[3] = 450; line_tab[4] = 599;
        for (int i = 5; i < NLINE; i++) line_tab[i] = 600 + (i - 5);

        rst_n = 1'b0; horz = 16'd0; vert = 16'd0; en = 1'b1;
        sx = 4'd3; sy = 4'd2;
        rand_steps = 0; rst_mid_pending = 0; rst_mid_done = 0;
        tick_seen = 0; skip_stable = 1; prev_v = 1000; prev_pack = 64'd0;
        model_reset();
        #12;
        check_val("rst_x", 64'(ox), 64'd0);
        check_val("rst_y", 64'(oy), 64'd0);
        check_val("rst_dir", {62'd0, odx, ody}, 64'd0);
        check_val("rst_pulses", {62'd0, otick, obounce}, 64'd0);
        rst_n = 1'b1;

        // first tick only advances the divider, second commits 3/2
        run_frame();
        check_val("frame1_x", 64'(ox), 64'd0);
        check_val("frame1_y", 64'(oy), 64'd0);
        run_frame();
        check_val("frame2_x", 64'(ox), 64'd3);
        check_val("frame2_y", 64'(oy), 64'd2);

        rand_steps = 1;
        for (int f = 0; f < 150; f++) begin
            en = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
            run_frame();
        end

        // frozen motion: ticks keep coming, nothing else moves
        sv_x = int'(ox); sv_y = int'(oy); sv_dx = int'(odx); sv_dy = int'(ody);
        en = 1'b0;
        tick_seen = 0;
        for (int f = 0; f < 5; f++) run_frame();
        check_val("hold_ticks", 64'(tick_seen), 64'd5);
        check_val("hold_x", 64'(ox), 64'(sv_x));
        check_val("hold_y", 64'(oy), 64'(sv_y));
        check_val("hold_dir", 64'({sv_dx[0], sv_dy[0]}), {62'd0, odx, ody});
        en = 1'b1;

        // move away from the reset position, then reset inside an update
        for (int f = 0; f < 4; f++) run_frame();
        sx = 4'd5; sy = 4'd4;
        rst_mid_pending = 1;
        for (int f = 0; f < 3; f++) run_frame();
        check_val("rst_mid_seen", 64'(rst_mid_done), 64'd1);

        for (int f = 0; f < 150; f++) begin
            en = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
            run_frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
